// File: rtl/icache_line_fill.sv
// Direct-mapped instruction cache with 4-word lines, serving 16-bit words to the fetch stage.
// Misses fetch a whole aligned line, data-port writes invalidate matching lines, and hits and misses are counted.
module icache_line_fill #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_LINES   = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] o_data,
  output logic                 o_stall,
  input  logic                 flush,
  input  logic                 snoop_we,
  input  logic [WORD_SIZE-1:0] snoop_addr,
  output logic                 readM1,
  output logic [WORD_SIZE-1:0] address1,
  input  logic [WORD_SIZE-1:0] data1_1,
  input  logic [WORD_SIZE-1:0] data1_2,
  input  logic [WORD_SIZE-1:0] data1_3,
  input  logic [WORD_SIZE-1:0] data1_4,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = WORD_SIZE - 2 - IW;
  localparam int CW = $clog2(MEM_LATENCY);
  localparam logic [CW-1:0] LAT_RELOAD = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [NUM_LINES-1:0] r_valid;
  logic [TW-1:0]        r_tag   [NUM_LINES];
  logic [WORD_SIZE-1:0] r_words [NUM_LINES][4];
  logic [WORD_SIZE-1:0] r_lineBuf [4];
  logic                 r_readM1;
  logic [WORD_SIZE-1:0] r_address1;
  logic [CW-1:0]        r_count;
  logic                 r_fillKill;
  logic                 r_skipHit;
  logic [15:0]          r_hitCount;
  logic [15:0]          r_missCount;

  logic                 w_nextReadM1;
  logic [WORD_SIZE-1:0] w_nextAddress1;
  logic [CW-1:0]        w_nextCount;
  logic                 w_nextFillKill;
  logic                 w_capture;
  logic                 w_fillWrite;
  logic                 w_missEvent;
  logic                 w_hit;
  logic                 w_snoopLineMatch;
  logic                 w_fillValid;
  logic [1:0]           w_off;
  logic [IW-1:0]        w_idx;
  logic [TW-1:0]        w_tag;
  logic [IW-1:0]        w_snoopIdx;
  logic [TW-1:0]        w_snoopTag;
  logic [IW-1:0]        w_fillIdx;
  logic [TW-1:0]        w_fillTag;
  logic                 w_unusedBits;

  assign w_off        = i_addr[1:0];
  assign w_idx        = i_addr[IW+1:2];
  assign w_tag        = i_addr[WORD_SIZE-1:IW+2];
  assign w_snoopIdx   = snoop_addr[IW+1:2];
  assign w_snoopTag   = snoop_addr[WORD_SIZE-1:IW+2];
  assign w_fillIdx    = r_address1[IW+1:2];
  assign w_fillTag    = r_address1[WORD_SIZE-1:IW+2];
  assign w_unusedBits = ^snoop_addr[1:0];

  assign w_hit = (r_state == IDLE) && i_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // A data-port write into the line being fetched makes the in-flight data stale.
  assign w_snoopLineMatch = snoop_we && (snoop_addr[WORD_SIZE-1:2] == r_address1[WORD_SIZE-1:2]);
  assign w_fillValid = !flush && !r_fillKill && !w_snoopLineMatch;

  always_comb begin
    o_stall = i_req && !w_hit;
    o_data  = '0;
    if (w_hit) o_data = r_words[w_idx][w_off];
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextReadM1   = r_readM1;
    w_nextAddress1 = r_address1;
    w_nextCount    = r_count;
    w_nextFillKill = r_fillKill;
    w_capture      = 1'b0;
    w_fillWrite    = 1'b0;
    w_missEvent    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req && !w_hit) begin
          w_nextState    = FETCH;
          w_nextReadM1   = 1'b1;
          w_nextAddress1 = {i_addr[WORD_SIZE-1:2], 2'b00};
          w_nextCount    = LAT_RELOAD;
          w_nextFillKill = 1'b0;
          w_missEvent    = 1'b1;
        end
      end
      FETCH: begin
        w_nextFillKill = r_fillKill || flush;
        if (w_snoopLineMatch) begin
          w_nextCount = LAT_RELOAD;
        end else if (r_count == '0) begin
          w_capture    = 1'b1;
          w_nextState  = FILL;
          w_nextReadM1 = 1'b0;
        end else begin
          w_nextCount = r_count - CW'(1);
        end
      end
      FILL: begin
        w_fillWrite = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_readM1    <= 1'b0;
      r_address1  <= '0;
      r_count     <= '0;
      r_fillKill  <= 1'b0;
      r_skipHit   <= 1'b0;
      r_hitCount  <= '0;
      r_missCount <= '0;
    end else begin
      r_state    <= w_nextState;
      r_readM1   <= w_nextReadM1;
      r_address1 <= w_nextAddress1;
      r_count    <= w_nextCount;
      r_fillKill <= w_nextFillKill;
      // The hit that returns a just-filled word belongs to the request already counted as a miss.
      r_skipHit  <= (r_state == FILL);
      if (w_hit && !r_skipHit) r_hitCount <= r_hitCount + 16'd1;
      if (w_missEvent) r_missCount <= r_missCount + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_lineBuf[0] <= data1_1;
      r_lineBuf[1] <= data1_2;
      r_lineBuf[2] <= data1_3;
      r_lineBuf[3] <= data1_4;
    end
  end

  // The line being filled takes its validity from w_fillValid; other lines honour flush, then snoop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (w_fillWrite && (w_fillIdx == IW'(i))) begin
          r_valid[i] <= w_fillValid;
          r_tag[i]   <= w_fillTag;
          r_words[i] <= r_lineBuf;
        end else if (flush) begin
          r_valid[i] <= 1'b0;
        end else if (snoop_we && (w_snoopIdx == IW'(i)) && (r_tag[i] == w_snoopTag)) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign readM1     = r_readM1;
  assign address1   = r_address1;
  assign hit_count  = r_hitCount;
  assign miss_count = r_missCount;

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: directed scenarios plus randomized traffic
// checked against a line-presence model of the cache and a word-addressed memory image.
module tb_icache_line_fill;

   localparam int LAT = 4;
   localparam int NL  = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = 16'h0;
   logic        flush = 1'b0;
   logic        snoop_we = 1'b0;
   logic [15:0] snoop_addr = 16'h0;
   logic [15:0] o_data;
   logic        o_stall;
   logic        readM1;
   logic [15:0] address1;
   logic [15:0] data1_1, data1_2, data1_3, data1_4;
   logic [15:0] hit_count, miss_count;

   logic [15:0] mem [0:255];
   int          modelLine [NL];
   int          expHit;
   int          expMiss;
   int          total = 0;
   int          bad = 0;

   icache_line_fill #(.WORD_SIZE(16), .NUM_LINES(NL), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_addr(i_addr),
      .o_data(o_data), .o_stall(o_stall), .flush(flush),
      .snoop_we(snoop_we), .snoop_addr(snoop_addr),
      .readM1(readM1), .address1(address1),
      .data1_1(data1_1), .data1_2(data1_2), .data1_3(data1_3), .data1_4(data1_4),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // Instruction memory answers the line read combinationally; the cache decides when to sample it.
   assign data1_1 = mem[{address1[7:2], 2'd0}];
   assign data1_2 = mem[{address1[7:2], 2'd1}];
   assign data1_3 = mem[{address1[7:2], 2'd2}];
   assign data1_4 = mem[{address1[7:2], 2'd3}];

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One clock: inputs change 1 after the edge, outputs are sampled 2 after it.
   task automatic applyStimulus(input logic req, input logic [15:0] addr, input logic fl,
                                input logic sw, input logic [15:0] sa);
      @(posedge clk);
      #1;
      i_req = req;
      i_addr = addr;
      flush = fl;
      snoop_we = sw;
      snoop_addr = sa;
      if (sw) mem[sa[7:0]] = 16'($urandom);
      #1;
   endtask

   function automatic int lineOf(input logic [15:0] a);
      return int'(a[15:2]);
   endfunction

   function automatic int idxOf(input logic [15:0] a);
      return int'(a[15:2]) % NL;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NL; i++) modelLine[i] = -1;
      expHit = 0;
      expMiss = 0;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      i_req = 1'b0;
      flush = 1'b0;
      snoop_we = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      modelReset();
   endtask

   // Holds one fetch until it is served; evKind 1 = snoop of evAddr, 2 = flush, at cycle evCycle.
   task automatic runRequest(input logic [15:0] addr, input int evCycle, input int evKind,
                             input logic [15:0] evAddr, output int stalls, output int reads,
                             output logic [15:0] data);
      bit done = 1'b0;
      stalls = 0;
      reads = 0;
      data = 16'h0;
      for (int c = 0; c < 64 && !done; c++) begin
         applyStimulus(1'b1, addr, evKind == 2 && c == evCycle, evKind == 1 && c == evCycle, evAddr);
         if (readM1) begin
            reads++;
            checkOutput("address1", 32'(address1), 32'({addr[15:2], 2'b00}));
         end
         if (o_stall) stalls++;
         else begin
            data = o_data;
            done = 1'b1;
         end
      end
      checkOutput("req_done", 32'(done), 32'd1);
   endtask

   task automatic doRequest(input logic [15:0] addr);
      int s, r;
      logic [15:0] d;
      bit isHit = (modelLine[idxOf(addr)] == lineOf(addr));
      runRequest(addr, -1, 0, 16'h0, s, r, d);
      checkOutput("stall_cycles", 32'(s), isHit ? 32'd0 : 32'(LAT + 2));
      checkOutput("readM1_cycles", 32'(r), isHit ? 32'd0 : 32'(LAT));
      checkOutput("fetch_data", 32'(d), 32'(mem[addr[7:0]]));
      if (isHit) expHit++;
      else begin
         expMiss++;
         modelLine[idxOf(addr)] = lineOf(addr);
      end
   endtask

   task automatic doIdle(input logic fl, input logic sw, input logic [15:0] sa);
      applyStimulus(1'b0, 16'h0, fl, sw, sa);
      checkOutput("idle_stall", 32'(o_stall), 32'd0);
      checkOutput("idle_data", 32'(o_data), 32'd0);
      checkOutput("idle_readM1", 32'(readM1), 32'd0);
      checkOutput("hit_count", 32'(hit_count), 32'(expHit & 16'hFFFF));
      checkOutput("miss_count", 32'(miss_count), 32'(expMiss & 16'hFFFF));
      if (fl) begin
         for (int i = 0; i < NL; i++) modelLine[i] = -1;
      end else if (sw && modelLine[idxOf(sa)] == lineOf(sa)) begin
         modelLine[idxOf(sa)] = -1;
      end
   endtask

   initial begin
      int s, r, op;
      logic [15:0] d;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h9023;
      mem[1] = 16'h0001;
      mem[2] = 16'hFFFF;
      mem[3] = 16'h0000;
      mem[8'h23] = 16'h6000;

      // Reset state, cold miss, then line reuse without further memory traffic.
      doReset();
      doIdle(1'b0, 1'b0, 16'h0);
      checkOutput("reset_address1", 32'(address1), 32'd0);
      doRequest(16'h0000);
      doIdle(1'b0, 1'b0, 16'h0);
      doRequest(16'h0001);
      doRequest(16'h0002);
      doRequest(16'h0003);
      doIdle(1'b0, 1'b0, 16'h0);
      checkOutput("reuse_hits", 32'(hit_count), 32'd3);

      // Conflict on index 0, then a snoop while idle drops line 0.
      doReset();
      doRequest(16'h0023);
      doRequest(16'h0000);
      doIdle(1'b0, 1'b0, 16'h0);
      checkOutput("conflict_misses", 32'(miss_count), 32'd2);
      doIdle(1'b0, 1'b1, 16'h0002);
      doRequest(16'h0000);
      doIdle(1'b0, 1'b0, 16'h0);

      // Snoop of the line in flight restarts the fetch and the fresh word is returned.
      doReset();
      runRequest(16'h0000, 2, 1, 16'h0002, s, r, d);
      checkOutput("snoop_fetch_stalls", 32'(s), 32'(LAT + 4));
      checkOutput("snoop_fetch_reads", 32'(r), 32'(LAT + 2));
      checkOutput("snoop_fetch_data", 32'(d), 32'(mem[0]));
      expMiss++;
      modelLine[0] = 0;
      doRequest(16'h0002);
      doIdle(1'b0, 1'b0, 16'h0);

      // Flush during a fetch: the fill lands invalid, so the held request misses a second time.
      doReset();
      runRequest(16'h0008, 2, 2, 16'h0, s, r, d);
      checkOutput("flush_fetch_stalls", 32'(s), 32'(2 * (LAT + 2)));
      checkOutput("flush_fetch_reads", 32'(r), 32'(2 * LAT));
      checkOutput("flush_fetch_data", 32'(d), 32'(mem[8]));
      expMiss += 2;
      modelLine[2] = 2;
      doIdle(1'b0, 1'b0, 16'h0);

      // Reset asserted in the second fetch cycle.
      doReset();
      applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);
      checkOutput("rst_mid_miss_stall", 32'(o_stall), 32'd1);
      applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);
      checkOutput("rst_mid_readM1_before", 32'(readM1), 32'd1);
      reset_n = 1'b0;
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
      checkOutput("rst_mid_readM1_after", 32'(readM1), 32'd0);
      checkOutput("rst_mid_miss_count", 32'(miss_count), 32'd0);
      checkOutput("rst_mid_hit_count", 32'(hit_count), 32'd0);
      reset_n = 1'b1;
      modelReset();
      doRequest(16'h0000);
      doIdle(1'b0, 1'b0, 16'h0);

      // Randomized traffic over 16 lines competing for 4 cache slots.
      doReset();
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      for (int n = 0; n < 400; n++) begin
         op = int'($urandom_range(0, 99));
         if (op < 65) doRequest(16'($urandom_range(0, 63)));
         else if (op < 82) doIdle(1'b0, 1'b0, 16'h0);
         else if (op < 95) doIdle(1'b0, 1'b1, 16'($urandom_range(0, 63)));
         else doIdle(1'b1, 1'b0, 16'h0);
      end
      doIdle(1'b0, 1'b0, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Direct-mapped instruction cache between the CPU fetch stage and the instruction port of the 4-word-line memory.
- Serves single 16-bit instruction words to the CPU.
- On a miss, requests a whole aligned 4-word line over readM1/address1 and captures data1_1..data1_4 after a fixed memory latency.
- Invalidates lines on data-port writes (snoop) and keeps hit/miss statistics.

Parameters:
- WORD_SIZE, 16, data/address width.
- NUM_LINES, 4, number of cache lines; power of two, index width = log2(NUM_LINES).
- MEM_LATENCY, 4, cycles readM1 is held before line data is captured; must be >= 2.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- i_req  input  1  CPU fetch request
- i_addr  input  WORD_SIZE  CPU word address
- o_data  output  WORD_SIZE  instruction word; valid when i_req=1 and o_stall=0
- o_stall  output  1  CPU must hold i_req/i_addr
- flush  input  1  invalidate all lines
- snoop_we  input  1  data-port write in progress (writeM2)
- snoop_addr  input  WORD_SIZE  data-port write address (address2)
- readM1  output  1  memory line read request
- address1  output  WORD_SIZE  line base address, low 2 bits 0
- data1_1..data1_4  input  WORD_SIZE each  memory line words at offsets 0..3
- hit_count  output  16  counted hits, wraps
- miss_count  output  16  counted misses, wraps

Behaviour:
- Clock and reset: reset reset_n, synchronous, active-low; clock clk.
- Reset values: all valid bits 0, state IDLE, readM1=0, address1=0, hit_count=0, miss_count=0, latency counter 0.
- Reset mid-FETCH aborts the fill: readM1=0 on the next cycle, nothing is validated.
- Address split: offset=i_addr[1:0], index=i_addr[2+IW-1:2], tag=remaining upper bits.
- Per line storage: valid, tag, 4 words.
- Hit (combinational): state IDLE, i_req=1, valid[index]=1, tag match.
  - o_stall=0; o_data=word[offset].
- Otherwise o_stall=i_req. When i_req=0, o_stall=0 and o_data=0.
- States:
  - IDLE: on i_req and miss -> FETCH. address1 <= {i_addr[15:2],2'b00}; readM1 <= 1; counter <= MEM_LATENCY-1; miss_count += 1.
  - FETCH: readM1=1 and address1 held; counter decrements each cycle. In the cycle counter==0, capture data1_1..4 and go to FILL with readM1 <= 0. FETCH therefore lasts exactly MEM_LATENCY cycles.
  - FILL: write words, tag and valid=1 into the indexed line; -> IDLE. The next cycle hits if the request is unchanged.
- Miss-to-data latency: MEM_LATENCY+2 cycles after the miss cycle.
- hit_count increments on each IDLE hit cycle, except the first hit after a FILL for the same request. A refill return is not counted, so each request is counted exactly once.
- Snoop: when snoop_we=1 and the line indexed by snoop_addr has a matching tag, clear its valid bit that cycle.
  - In FETCH, if snoop_addr[15:2] equals address1[15:2], reload counter to MEM_LATENCY-1 and stay in FETCH (refetch so fresh data is captured).
- flush: clears all valid bits that cycle.
  - A fill in progress still completes but writes valid=0.
  - Flush takes priority over a simultaneous FILL validate and over a snoop.
- Same-cycle IDLE hit and snoop to that line: the hit is served from old data; the invalidate takes effect next cycle.
- Counters wrap 0xFFFF -> 0x0000.
- i_addr changing while o_stall=1 is illegal; behaviour is unspecified but must not corrupt other lines.

Test Plan:
- Cold miss: reset, memory preloaded (0x0000=0x9023, 0x1=0x0001, 0x2=0xFFFF), i_req=1, i_addr=0x0000, MEM_LATENCY=4.
  - address1=0x0000 and readM1=1 for 4 cycles.
  - o_stall=0 with o_data=0x9023 in cycle 6.
  - miss_count=1, hit_count=0.
- Line reuse: after the cold miss, fetch 0x0001, 0x0002, 0x0003 back-to-back.
  - o_data=0x0001, 0xFFFF, 0x0000 with no stall.
  - hit_count=3, readM1 never asserted.
- Conflict: fetch 0x0023 (line 0x20, index 0 with NUM_LINES=4... tag differs) then 0x0000.
  - o_data=0x6000, then 0x9023.
  - Both are misses; miss_count=2.
- Snoop: line 0x0000 cached, snoop_we=1 with snoop_addr=0x0002 for one cycle, then fetch 0x0000 → miss.
  - Repeat with the snoop during FETCH of the same line: counter reloads, FETCH lasts 4 cycles past the snoop.
- Flush during FETCH: the fill completes, the next request to the same address misses again (miss_count increments, readM1 reasserted).
- Reset in the 2nd FETCH cycle: readM1=0 next cycle, counters=0, the following fetch of 0x0000 misses.
